// File: rtl/kgp_seq_adder.sv
// kgp_seq_adder: multi-cycle WIDTH-bit add/sub built on a KGP prefix carry
// network, resolving one log-step prefix round per clock.
// Ports: clk, rst (sync, active-high); in_valid/in_ready + a, b, sub operand
// side; out_valid/out_ready + sum, cout, overflow, carries result side.
module kgp_seq_adder #(
  parameter  int WIDTH  = 64,
  localparam int ROUNDS = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic [WIDTH-1:0] carries
);

  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [RW-1:0] RLAST = RW'(ROUNDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    ENC,
    PREFIX,
    SUM,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]      a_q, b_q;
  logic                  cin_q;
  logic [WIDTH-1:0][1:0] code_q;
  logic [WIDTH-1:0][1:0] enc;
  logic [WIDTH-1:0][1:0] rnd [ROUNDS];
  logic [RW-1:0]         r_q;
  logic [WIDTH-1:0]      c;

  logic [WIDTH-1:0] sum_q, car_q;
  logic             cout_q, ovf_q;

  // K (00) and G (11) are the codes with equal bits; they override prev.
  function automatic logic [1:0] combine(
    input logic [1:0] prev,
    input logic [1:0] cur
  );
    return (cur[1] == cur[0]) ? cur : prev;
  endfunction

  // Carry-in is folded into position 0, so no P survives the prefix.
  assign enc[0] = combine({cin_q, cin_q}, {a_q[0], b_q[0]});

  for (genvar i = 1; i < WIDTH; i++) begin : g_enc
    assign enc[i] = {a_q[i], b_q[i]};
  end

  // One candidate result per round; the round counter selects which applies.
  for (genvar k = 0; k < ROUNDS; k++) begin : g_rnd
    for (genvar i = 0; i < WIDTH; i++) begin : g_pos
      if (i >= (1 << k)) begin : g_cmb
        assign rnd[k][i] = combine(code_q[i-(1<<k)], code_q[i]);
      end else begin : g_pass
        assign rnd[k][i] = code_q[i];
      end
    end
  end

  assign c[0] = cin_q;
  for (genvar i = 1; i < WIDTH; i++) begin : g_car
    assign c[i] = code_q[i-1][1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = ENC;
      ENC:     state_d = PREFIX;
      PREFIX:  if (r_q == RLAST) state_d = SUM;
      SUM:     state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      cin_q  <= 1'b0;
      code_q <= '0;
      r_q    <= '0;
      sum_q  <= '0;
      car_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b ^ {WIDTH{sub}};
            cin_q <= sub;
          end
        end
        ENC: begin
          code_q <= enc;
          r_q    <= '0;
        end
        PREFIX: begin
          code_q <= rnd[r_q];
          r_q    <= r_q + 1'b1;
        end
        SUM: begin
          sum_q  <= a_q ^ b_q ^ c;
          car_q  <= c;
          cout_q <= code_q[WIDTH-1][1];
          ovf_q  <= c[WIDTH-1] ^ code_q[WIDTH-1][1];
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign carries   = car_q;

endmodule

// File: tb/tb_kgp_seq_adder.sv
// tb_kgp_seq_adder: scoreboard bench for kgp_seq_adder with an arithmetic
// reference model, directed corner cases and random vectors.
module tb_kgp_seq_adder;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;
  logic [W-1:0] carries;

  kgp_seq_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow),
    .carries  (carries)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic [W-1:0] car;
  } exp_t;

  exp_t   expq[$];
  longint accq[$];
  longint cyc = 0;
  longint last_acc = 0;
  int     errors = 0;
  int     checks = 0;
  int     nsent = 0;
  int     nres = 0;
  bit     rand_rdy = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain two's-complement arithmetic on wide integers.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic s);
    exp_t e;
    logic [W:0] wide;
    logic signed [W:0] sx;
    if (s) begin
      e.sum  = x - y;
      e.cout = (x >= y);
      sx = $signed({x[W-1], x}) - $signed({y[W-1], y});
    end else begin
      wide   = {1'b0, x} + {1'b0, y};
      e.sum  = wide[W-1:0];
      e.cout = wide[W];
      sx = $signed({x[W-1], x}) + $signed({y[W-1], y});
    end
    e.ovf = sx[W] ^ sx[W-1];
    e.car = e.sum ^ x ^ (s ? ~y : y);
    return e;
  endfunction

  // Monitor: latency on each rising out_valid, result on each handshake.
  initial begin : monitor
    exp_t e;
    logic pv;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (out_valid && !pv) begin
          if (accq.size() != 0) begin
            chk("latency", W'(cyc - accq.pop_front()), 64'd8);
          end else begin
            checks++;
            errors++;
            $display("FAIL stray_valid: got out_valid=1 expected no pending op");
          end
        end
        if (out_valid && out_ready) begin
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got sum=%h expected none", sum);
          end else begin
            e = expq.pop_front();
            chk("sum", sum, e.sum);
            chk("cout", W'(cout), W'(e.cout));
            chk("overflow", W'(overflow), W'(e.ovf));
            chk("carries", carries, e.car);
            nres++;
          end
        end
        pv = out_valid;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = 1'($urandom);
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic s, input bit hold);
    int n;
    in_valid = 1'b1;
    a = x;
    b = y;
    sub = s;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 300);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end else begin
      expq.push_back(model(x, y, s));
      accq.push_back(cyc + 1);
      last_acc = cyc + 1;
      nsent++;
    end
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((expq.size() != 0 || !in_ready) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (expq.size() != 0 || !in_ready) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got pending=%0d expected 0", expq.size());
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand_op();
    unique case ($urandom_range(0, 4))
      0:       return 64'hFFFF_FFFF_FFFF_FFFF;
      1:       return 64'h8000_0000_0000_0000;
      2:       return 64'h7FFF_FFFF_FFFF_FFFF;
      3:       return W'($urandom_range(0, 15));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin : driver
    logic [W-1:0] s0;
    logic         c0;
    longint       t0;
    int           n;
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    sub = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", W'(in_ready), 64'd1);
    chk("rst_out_valid", W'(out_valid), 64'd0);
    chk("rst_sum", sum, 64'd0);
    chk("rst_cout", W'(cout), 64'd0);
    chk("rst_overflow", W'(overflow), 64'd0);
    chk("rst_carries", carries, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    wait_idle();
    send(64'd5, 64'd7, 1'b1, 1'b0);
    wait_idle();
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    wait_idle();
    send(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0);
    wait_idle();

    // Backpressure: result held while the consumer stalls.
    out_ready = 1'b0;
    send(64'd123, 64'd456, 1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", W'(out_valid), 64'd1);
    s0 = sum;
    c0 = cout;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      in_valid = ~in_valid;
      a = {$urandom, $urandom};
      @(negedge clk);
      chk("bp_sum_stable", sum, s0);
      chk("bp_cout_stable", W'(cout), W'(c0));
      chk("bp_in_ready", W'(in_ready), 64'd0);
      chk("bp_out_valid", W'(out_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_in_ready", W'(in_ready), 64'd1);
    chk("bp_idle_out_valid", W'(out_valid), 64'd0);
    chk("bp_no_extra", W'(expq.size()), 64'd0);
    @(posedge clk);
    #1;

    // Abort during prefix round 3.
    send(64'd9, 64'd9, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    void'(expq.pop_back());
    void'(accq.pop_back());
    nsent--;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", W'(in_ready), 64'd1);
    chk("abort_out_valid", W'(out_valid), 64'd0);
    chk("abort_sum", sum, 64'd0);
    chk("abort_cout", W'(cout), 64'd0);
    @(posedge clk);
    #1;
    send(64'd3, 64'd4, 1'b0, 1'b0);
    wait_idle();

    // Streaming with in_valid and out_ready held high.
    send(64'd1, 64'd2, 1'b0, 1'b1);
    t0 = last_acc;
    send(64'd100, 64'd1, 1'b1, 1'b1);
    chk("stream_ii_1", W'(last_acc - t0), 64'd10);
    t0 = last_acc;
    send(64'd0, 64'd0, 1'b1, 1'b0);
    chk("stream_ii_2", W'(last_acc - t0), 64'd10);
    wait_idle();

    // Random vectors with a randomly stalling consumer.
    rand_rdy = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      send(rand_op(), rand_op(), 1'($urandom), 1'b0);
    end
    wait_idle();
    rand_rdy = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle();
    chk("result_count", W'(nres), W'(nsent));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
